rocket_sprite_core: RTL and testbench

//  Pixel-pipeline stage directly downstream of the 32x32 2-bit sprite bitmap RAM.
//  - Read side: maps frame x/y to a sprite-relative RAM read address, takes the RAM's

---
 rtl/rocket_sprite_core.sv | 132 +++++++++++++
 tb/tb_rocket_sprite_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rocket_sprite_core.sv
// rtl/rocket_sprite_core.sv - sprite overlay stage: bus bridge to sprite RAM, origin shadowing, palette compositing
// Fixed two-cycle pixel latency from x/y/si_rgb to sprite_rgb; no stalls.
module rocket_sprite_core #(
  parameter int         CD         = 12,
  parameter int         ADDR_WIDTH = 10,
  parameter int         SPR_BITS   = 5,
  parameter logic [1:0] KEY_CODE   = 2'd0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic [CD-1:0]         si_rgb,
  input  logic                  frame_start,
  input  logic                  wr_en,
  input  logic [13:0]           wr_addr,
  input  logic [31:0]           wr_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [1:0]            ram_din,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [1:0]            ram_dout,
  output logic [CD-1:0]         sprite_rgb
);

  localparam logic [10:0] SPR_SIZE = 11'(1 << SPR_BITS);

  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_w_q, ram_addr_w_d;
  logic [1:0]            ram_din_q, ram_din_d;
  logic [10:0]           x0_pend_q, x0_pend_d, y0_pend_q, y0_pend_d;
  logic [10:0]           x0_q, x0_d, y0_q, y0_d;
  logic                  bypass_q, bypass_d;
  logic [CD-1:0]         pal1_q, pal1_d, pal2_q, pal2_d, pal3_q, pal3_d;
  logic                  in_reg_d1_q, in_reg_d1_d;
  logic [CD-1:0]         si_rgb_d1_q, si_rgb_d1_d;
  logic [CD-1:0]         sprite_rgb_q, sprite_rgb_d;
  logic [10:0]           xr, yr;
  logic                  in_reg;
  logic                  unused_bits;

  assign unused_bits = ^{wr_data[31:CD], wr_addr[12:ADDR_WIDTH]};

  always_comb begin
    ram_we_d     = wr_en & ~wr_addr[13];
    ram_addr_w_d = ram_addr_w_q;
    ram_din_d    = ram_din_q;
    x0_pend_d    = x0_pend_q;
    y0_pend_d    = y0_pend_q;
    bypass_d     = bypass_q;
    pal1_d       = pal1_q;
    pal2_d       = pal2_q;
    pal3_d       = pal3_q;
    if (ram_we_d) begin
      ram_addr_w_d = wr_addr[ADDR_WIDTH-1:0];
      ram_din_d    = wr_data[1:0];
    end
    if (wr_en && wr_addr[13]) begin
      case (wr_addr[2:0])
        3'd0:    x0_pend_d = wr_data[10:0];
        3'd1:    y0_pend_d = wr_data[10:0];
        3'd2:    bypass_d  = wr_data[0];
        3'd4:    pal1_d    = wr_data[CD-1:0];
        3'd5:    pal2_d    = wr_data[CD-1:0];
        3'd6:    pal3_d    = wr_data[CD-1:0];
        default: ;
      endcase
    end

    // Origin loaded at frame_start is used for that very first pixel too.
    x0_d = frame_start ? x0_pend_d : x0_q;
    y0_d = frame_start ? y0_pend_d : y0_q;

    xr         = x - x0_d;
    yr         = y - y0_d;
    in_reg     = (xr < SPR_SIZE) && (yr < SPR_SIZE);
    ram_addr_r = {yr[SPR_BITS-1:0], xr[SPR_BITS-1:0]};

    in_reg_d1_d = in_reg;
    si_rgb_d1_d = si_rgb;

    sprite_rgb_d = si_rgb_d1_q;
    if (!bypass_q && in_reg_d1_q && ram_dout != KEY_CODE) begin
      case (ram_dout)
        2'd1:    sprite_rgb_d = pal1_q;
        2'd2:    sprite_rgb_d = pal2_q;
        2'd3:    sprite_rgb_d = pal3_q;
        default: sprite_rgb_d = si_rgb_d1_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_we_q     <= 1'b0;
      ram_addr_w_q <= '0;
      ram_din_q    <= '0;
      x0_pend_q    <= '0;
      y0_pend_q    <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      bypass_q     <= 1'b1;
      pal1_q       <= CD'(12'hF00);
      pal2_q       <= CD'(12'hFFF);
      pal3_q       <= CD'(12'h888);
      in_reg_d1_q  <= 1'b0;
      si_rgb_d1_q  <= '0;
      sprite_rgb_q <= '0;
    end else begin
      ram_we_q     <= ram_we_d;
      ram_addr_w_q <= ram_addr_w_d;
      ram_din_q    <= ram_din_d;
      x0_pend_q    <= x0_pend_d;
      y0_pend_q    <= y0_pend_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      bypass_q     <= bypass_d;
      pal1_q       <= pal1_d;
      pal2_q       <= pal2_d;
      pal3_q       <= pal3_d;
      in_reg_d1_q  <= in_reg_d1_d;
      si_rgb_d1_q  <= si_rgb_d1_d;
      sprite_rgb_q <= sprite_rgb_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr_w = ram_addr_w_q;
  assign ram_din    = ram_din_q;
  assign sprite_rgb = sprite_rgb_q;

endmodule

// File: tb/tb_rocket_sprite_core.sv
// tb/tb_rocket_sprite_core.sv - bench for rocket_sprite_core with sprite RAM fixture and reference model
module tb_rocket_sprite_core;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] x = '0, y = '0;
  logic [11:0] si_rgb = '0;
  logic        frame_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [13:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        ram_we;
  logic [9:0]  ram_addr_w, ram_addr_r;
  logic [1:0]  ram_din;
  logic [1:0]  ram_dout = '0;
  logic [11:0] sprite_rgb;

  always #5 clk = ~clk;

  rocket_sprite_core dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .si_rgb(si_rgb),
    .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_we(ram_we), .ram_addr_w(ram_addr_w), .ram_din(ram_din),
    .ram_addr_r(ram_addr_r), .ram_dout(ram_dout), .sprite_rgb(sprite_rgb)
  );

  // Sprite RAM: registered read, read-before-write.
  logic [1:0] fx_mem [1024] = '{default: 2'd0};
  always @(posedge clk) begin
    ram_dout <= fx_mem[ram_addr_r];
    if (ram_we) fx_mem[ram_addr_w] <= ram_din;
  end

  int checks = 0, errors = 0;
  int m_px0, m_py0, m_ax0, m_ay0;
  bit m_byp;
  int m_pal [4];
  int m_mem [1024];
  bit pw_v;
  int pw_a, pw_d;
  int exp_aw, exp_din, exp_prev;
  int got;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_px0 = 0; m_py0 = 0; m_ax0 = 0; m_ay0 = 0; m_byp = 1;
    m_pal[0] = 0; m_pal[1] = 'hF00; m_pal[2] = 'hFFF; m_pal[3] = 'h888;
    pw_v = 0; exp_aw = 0; exp_din = 0; exp_prev = 0;
  endtask

  // One pixel clock: inputs are already on the DUT pins.
  task automatic cyc();
    int xr, yr, code, pix;
    bit inr;
    #1;
    if (wr_en && wr_addr[13]) begin
      case (wr_addr[2:0])
        3'd0: m_px0 = int'(wr_data[10:0]);
        3'd1: m_py0 = int'(wr_data[10:0]);
        3'd2: m_byp = wr_data[0];
        3'd4, 3'd5, 3'd6: m_pal[int'(wr_addr[2:0]) - 3] = int'(wr_data[11:0]);
        default: ;
      endcase
    end
    if (frame_start) begin
      m_ax0 = m_px0;
      m_ay0 = m_py0;
    end
    xr  = (int'(x) - m_ax0 + 2048) % 2048;
    yr  = (int'(y) - m_ay0 + 2048) % 2048;
    inr = (xr < 32) && (yr < 32);
    chk("ram_addr_r", int'(ram_addr_r), (yr % 32) * 32 + (xr % 32));
    code = inr ? m_mem[yr * 32 + xr] : 0;
    pix  = (m_byp || !inr || code == 0) ? int'(si_rgb) : m_pal[code];
    if (pw_v) m_mem[pw_a] = pw_d;
    pw_v = wr_en && !wr_addr[13];
    pw_a = int'(wr_addr[9:0]);
    pw_d = int'(wr_data[1:0]);
    if (pw_v) begin
      exp_aw  = pw_a;
      exp_din = pw_d;
    end
    @(posedge clk);
    #1;
    chk("ram_we", int'(ram_we), int'(pw_v));
    chk("ram_addr_w", int'(ram_addr_w), exp_aw);
    chk("ram_din", int'(ram_din), exp_din);
    chk("sprite_rgb", int'(sprite_rgb), exp_prev);
    exp_prev = pix;
  endtask

  task automatic drive(input int xx, input int yy, input int ss, input bit fs);
    x = 11'(xx); y = 11'(yy); si_rgb = 12'(ss); frame_start = fs; wr_en = 1'b0;
  endtask

  task automatic bus(input int a, input int d, input bit fs);
    wr_en = 1'b1; wr_addr = 14'(a); wr_data = 32'(d); frame_start = fs;
    cyc();
    wr_en = 1'b0; frame_start = 1'b0;
  endtask

  // Drive one pixel, then one more cycle so its result is on sprite_rgb.
  task automatic pix(input int xx, input int yy, input int ss, output int res);
    drive(xx, yy, ss, 0);
    cyc();
    cyc();
    res = int'(sprite_rgb);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", int'(sprite_rgb), 0);
    chk("reset_we", int'(ram_we), 0);
    @(negedge clk);
    reset_n = 1'b1;

    pix(5, 5, 'hABC, got);
    chk("bypass_after_reset", got, 'hABC);

    bus('h0021, 3, 0);
    chk("bmp_we", int'(ram_we), 1);
    chk("bmp_addr", int'(ram_addr_w), 'h021);
    chk("bmp_din", int'(ram_din), 3);
    cyc();
    chk("bmp_we_drop", int'(ram_we), 0);

    bus('h0000, 2, 0);
    bus('h2000, 100, 0);
    bus('h2001, 50, 0);
    bus('h2002, 0, 0);
    drive(0, 0, 0, 1);
    cyc();
    drive(0, 0, 0, 0);
    cyc();
    pix(100, 50, 'h123, got); chk("overlay_hit", got, 'hFFF);
    pix(99, 50, 'h123, got);  chk("overlay_left", got, 'h123);
    pix(132, 50, 'h456, got); chk("overlay_right", got, 'h456);
    pix(101, 50, 'h789, got); chk("overlay_key", got, 'h789);
    pix(101, 51, 'h111, got); chk("overlay_code3", got, 'h888);

    bus('h2000, 200, 0);
    pix(100, 50, 'h001, got); chk("shadow_hold", got, 'hFFF);
    drive(200, 50, 'h001, 0);
    bus('h2000, 200, 1);
    cyc();
    chk("shadow_same_cycle", int'(sprite_rgb), 'hFFF);

    bus('h0008, 3, 0);
    cyc();
    drive(0, 50, 'h222, 0);
    bus('h2000, 2040, 1);
    chk("wrap_addr", int'(ram_addr_r), 8);
    cyc();
    chk("wrap_pixel", int'(sprite_rgb), 'h888);

    bus('h2006, 'h0F0, 0);
    pix(0, 50, 'h003, got); chk("palette3", got, 'h0F0);

    bus('h0005, 1, 0);
    chk("pre_reset_we", int'(ram_we), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_rgb", int'(sprite_rgb), 0);
    chk("midreset_we", int'(ram_we), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pix(7, 7, 'hABC, got);
    chk("bypass_after_midreset", got, 'hABC);

    bus('h2000, 300, 0);
    bus('h2001, 200, 0);
    bus('h2002, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      int r, ox, oy;
      r = $urandom_range(0, 99);
      if (r < 50) begin
        ox = m_ax0 + $urandom_range(0, 40) - 4;
        oy = m_ay0 + $urandom_range(0, 40) - 4;
      end else begin
        ox = $urandom_range(0, 2047);
        oy = $urandom_range(0, 2047);
      end
      drive(ox, oy, $urandom_range(0, 4095), $urandom_range(0, 99) < 2);
      r = $urandom_range(0, 99);
      if (r < 12) begin
        wr_en = 1'b1;
        wr_addr = 14'($urandom_range(0, 1023));
        wr_data = $urandom();
      end else if (r < 18) begin
        wr_en = 1'b1;
        wr_addr = {1'b1, 10'($urandom()), 3'($urandom_range(0, 7))};
        wr_data = $urandom();
        if (wr_addr[2:0] == 3'd2) wr_data[0] = ($urandom_range(0, 3) == 0);
        if (wr_addr[2:0] <= 3'd1) wr_data[10:0] = 11'($urandom_range(0, 2047));
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
